// File: rtl/hash_work_scheduler_pkg.sv
// ============================================================================
// Module   : hash_work_scheduler_pkg
// Brief    : Shared state encodings, widths and helpers for the hash scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hash_work_scheduler_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam int unsigned c_nonce_w    = 32;
    localparam int unsigned c_midstate_w = 256;
    localparam int unsigned c_data_w     = 96;

    localparam logic [31:0] c_default_golden_target = 32'hA41F32E7;

    // Nonce counters wrap naturally at 2^32.
    function automatic logic [c_nonce_w-1:0] nonce_inc(input logic [c_nonce_w-1:0] n);
        return n + c_nonce_w'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hash_work_scheduler_gn_fifo.sv
// ============================================================================
// Module   : sched_gn_fifo
// Brief    : Synchronous golden-nonce FIFO; push while full is dropped unless
//            a pop happens in the same cycle, and sets a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sched_gn_fifo
    import hash_work_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH = c_nonce_w,
    parameter int unsigned DEPTH = 4
) (
    input  logic             hash_clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head_data,
    output logic             overflow
);

    localparam int unsigned       c_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_aw:0]     c_depth = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             r_overflow;

    logic w_pop;
    logic w_full;
    logic w_push;

    assign w_pop  = pop && (r_count != '0);
    assign w_full = (r_count == c_depth);
    // A pop in the same cycle frees the slot, so a push on full still lands.
    assign w_push = push && (!w_full || w_pop);

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (c_aw + 1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (c_aw + 1)'(1);
            end
            if (push && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign valid     = (r_count != '0);
    assign head_data = r_mem[r_rd_ptr];
    assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: rtl/hash_work_scheduler.sv
// ============================================================================
// Module   : hash_work_scheduler
// Brief    : Feeds one SHA-256d pipeline a nonce per cycle, realigns results
//            with their nonce across the fixed latency, queues golden nonces.
//            Optional: SCHED_PENDING_WORK_EN adds a one-entry work buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hash_work_scheduler
    import hash_work_scheduler_pkg::*;
#(
    parameter int unsigned PIPE_LATENCY  = 254,
    parameter logic [31:0] GOLDEN_TARGET = c_default_golden_target,
    parameter int unsigned GN_FIFO_DEPTH = 4
) (
    input  logic                    hash_clk,
    input  logic                    reset,
    input  logic                    work_valid,
    output logic                    work_ready,
    input  logic [c_midstate_w-1:0] work_midstate,
    input  logic [c_data_w-1:0]     work_data,
    input  logic [c_nonce_w-1:0]    work_nonce_start,
    input  logic [c_nonce_w-1:0]    work_nonce_end,
    output logic [c_midstate_w-1:0] hasher_midstate,
    output logic [c_data_w-1:0]     hasher_data,
    output logic [c_nonce_w-1:0]    hasher_nonce,
    input  logic [31:0]             hasher_hash,
    output logic                    gn_valid,
    input  logic                    gn_ready,
    output logic [c_nonce_w-1:0]    gn_nonce,
    output logic                    busy,
    output logic                    gn_overflow
);

    localparam int unsigned           c_fill_w    = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
    localparam logic [c_fill_w-1:0]   c_fill_last = c_fill_w'(PIPE_LATENCY - 1);

    logic [1:0]              r_state;
    logic [c_nonce_w-1:0]    r_issue_nonce;
    logic [c_nonce_w-1:0]    r_check_nonce;
    logic [c_nonce_w-1:0]    r_end;
    logic                    r_issue_active;
    logic [c_fill_w-1:0]     r_fill_cnt;
    logic [c_midstate_w-1:0] r_midstate;
    logic [c_data_w-1:0]     r_data;

    logic                    w_start;
    logic [c_midstate_w-1:0] w_start_midstate;
    logic [c_data_w-1:0]     w_start_data;
    logic [c_nonce_w-1:0]    w_start_nonce;
    logic [c_nonce_w-1:0]    w_start_end;
    logic                    w_check_en;
    logic                    w_hit;

`ifdef SCHED_PENDING_WORK_EN
    logic                    r_pend_full;
    logic [c_midstate_w-1:0] r_pend_midstate;
    logic [c_data_w-1:0]     r_pend_data;
    logic [c_nonce_w-1:0]    r_pend_start;
    logic [c_nonce_w-1:0]    r_pend_end;
    logic                    w_accept;
    logic                    w_start_pend;

    assign work_ready   = !r_pend_full;
    assign w_accept     = work_valid && work_ready;
    // Buffered work launches from IDLE, one cycle after the previous range ends.
    assign w_start_pend = r_pend_full && (r_state == S_IDLE);
    assign w_start      = w_start_pend || (w_accept && (r_state == S_IDLE));

    assign w_start_midstate = w_start_pend ? r_pend_midstate : work_midstate;
    assign w_start_data     = w_start_pend ? r_pend_data     : work_data;
    assign w_start_nonce    = w_start_pend ? r_pend_start    : work_nonce_start;
    assign w_start_end      = w_start_pend ? r_pend_end      : work_nonce_end;

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            r_pend_full     <= 1'b0;
            r_pend_midstate <= '0;
            r_pend_data     <= '0;
            r_pend_start    <= '0;
            r_pend_end      <= '0;
        end else if (w_start_pend) begin
            r_pend_full <= 1'b0;
        end else if (w_accept && (r_state != S_IDLE)) begin
            r_pend_full     <= 1'b1;
            r_pend_midstate <= work_midstate;
            r_pend_data     <= work_data;
            r_pend_start    <= work_nonce_start;
            r_pend_end      <= work_nonce_end;
        end
    end
`else
    // New work always preempts whatever range is in flight.
    assign work_ready       = 1'b1;
    assign w_start          = work_valid;
    assign w_start_midstate = work_midstate;
    assign w_start_data     = work_data;
    assign w_start_nonce    = work_nonce_start;
    assign w_start_end      = work_nonce_end;
`endif

    assign w_check_en = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_hit      = w_check_en && (hasher_hash == GOLDEN_TARGET);

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_issue_nonce  <= '0;
            r_check_nonce  <= '0;
            r_end          <= '0;
            r_issue_active <= 1'b0;
            r_fill_cnt     <= '0;
            r_midstate     <= '0;
            r_data         <= '0;
        end else if (w_start) begin
            r_midstate     <= w_start_midstate;
            r_data         <= w_start_data;
            r_issue_nonce  <= w_start_nonce;
            r_check_nonce  <= w_start_nonce;
            r_end          <= w_start_end;
            r_fill_cnt     <= '0;
            r_issue_active <= 1'b1;
            r_state        <= S_FILL;
        end else begin
            if (r_issue_active) begin
                if (r_issue_nonce == r_end) begin
                    r_issue_active <= 1'b0;
                end else begin
                    r_issue_nonce <= nonce_inc(r_issue_nonce);
                end
            end
            case (r_state)
                S_FILL: begin
                    r_fill_cnt <= r_fill_cnt + c_fill_w'(1);
                    if (r_fill_cnt == c_fill_last) begin
                        r_state <= r_issue_active ? S_RUN : S_DRAIN;
                    end
                end
                S_RUN, S_DRAIN: begin
                    r_check_nonce <= nonce_inc(r_check_nonce);
                    if (r_check_nonce == r_end) begin
                        r_state <= S_IDLE;
                    end else if (!r_issue_active) begin
                        r_state <= S_DRAIN;
                    end
                end
                default: ;
            endcase
        end
    end

    sched_gn_fifo #(
        .WIDTH (c_nonce_w),
        .DEPTH (GN_FIFO_DEPTH)
    ) u_gn_fifo (
        .hash_clk  (hash_clk),
        .reset     (reset),
        .push      (w_hit),
        .push_data (r_check_nonce),
        .pop       (gn_ready),
        .valid     (gn_valid),
        .head_data (gn_nonce),
        .overflow  (gn_overflow)
    );

    assign hasher_midstate = r_midstate;
    assign hasher_data     = r_data;
    assign hasher_nonce    = r_issue_nonce;
    assign busy            = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_hash_work_scheduler.sv
// ============================================================================
// Module   : tb_hash_work_scheduler
// Brief    : Scoreboard bench for hash_work_scheduler with a delay-line hasher.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hash_work_scheduler;
    import hash_work_scheduler_pkg::*;

    localparam int          L   = 8;
    localparam logic [31:0] TGT = 32'hA41F32E7;

    logic         hash_clk = 1'b0;
    logic         reset;
    logic         work_valid;
    logic         work_ready;
    logic [255:0] work_midstate;
    logic [95:0]  work_data;
    logic [31:0]  work_nonce_start;
    logic [31:0]  work_nonce_end;
    logic [255:0] hasher_midstate;
    logic [95:0]  hasher_data;
    logic [31:0]  hasher_nonce;
    logic [31:0]  hasher_hash;
    logic         gn_valid;
    logic         gn_ready;
    logic [31:0]  gn_nonce;
    logic         busy;
    logic         gn_overflow;

    hash_work_scheduler #(
        .PIPE_LATENCY  (L),
        .GOLDEN_TARGET (TGT),
        .GN_FIFO_DEPTH (4)
    ) dut (
        .hash_clk         (hash_clk),
        .reset            (reset),
        .work_valid       (work_valid),
        .work_ready       (work_ready),
        .work_midstate    (work_midstate),
        .work_data        (work_data),
        .work_nonce_start (work_nonce_start),
        .work_nonce_end   (work_nonce_end),
        .hasher_midstate  (hasher_midstate),
        .hasher_data      (hasher_data),
        .hasher_nonce     (hasher_nonce),
        .hasher_hash      (hasher_hash),
        .gn_valid         (gn_valid),
        .gn_ready         (gn_ready),
        .gn_nonce         (gn_nonce),
        .busy             (busy),
        .gn_overflow      (gn_overflow)
    );

    always #5 hash_clk = ~hash_clk;

    // Behavioural hasher: result for a nonce appears L cycles after it is presented.
    logic [31:0] hits [$];
    bit          hdl [L];
    logic [31:0] ndl [L];

    function automatic bit is_hit(input logic [31:0] n);
        foreach (hits[i]) if (hits[i] == n) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge hash_clk) begin
        hdl[0] <= is_hit(hasher_nonce);
        ndl[0] <= hasher_nonce;
        for (int i = 1; i < L; i++) begin
            hdl[i] <= hdl[i-1];
            ndl[i] <= ndl[i-1];
        end
    end

    assign hasher_hash = hdl[L-1] ? TGT : (TGT ^ {ndl[L-1][30:0], 1'b1});

    // Scoreboard
    logic [31:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    bit          saw_run;

    always @(negedge hash_clk) begin
        if (!reset && gn_valid && gn_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL gn_pop: got %h, required no pop (nothing expected)", gn_nonce);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (gn_nonce !== e) begin
                    errors++;
                    $display("FAIL gn_pop: got %h, required %h", gn_nonce, e);
                end
            end
        end
        if (dut.r_state == S_RUN) saw_run = 1'b1;
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge hash_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        work_valid = 1'b0;
        gn_ready   = 1'b0;
        tick(1);
        reset = 1'b0;
        exp_q.delete();
        hits.delete();
    endtask

    task automatic send_work(input logic [31:0] s, input logic [31:0] e);
        work_midstate    = {8{s ^ 32'h1234_5678}};
        work_data        = {3{e ^ 32'h0BAD_F00D}};
        work_nonce_start = s;
        work_nonce_end   = e;
        work_valid       = 1'b1;
        tick(1);
        work_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cyc, input int limit);
        cyc = 0;
        while (busy && cyc < limit) begin
            cyc++;
            tick(1);
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got busy after %0d cycles, required idle", cyc);
        end
    endtask

    initial begin
        int c;
        reset            = 1'b1;
        work_valid       = 1'b0;
        gn_ready         = 1'b0;
        work_midstate    = '0;
        work_data        = '0;
        work_nonce_start = '0;
        work_nonce_end   = '0;
        saw_run          = 1'b0;
        tick(2);
        do_reset();

        check("rst_busy", {31'd0, busy}, 0);
        check("rst_gn_valid", {31'd0, gn_valid}, 0);
        check("rst_overflow", {31'd0, gn_overflow}, 0);
        check("rst_nonce", hasher_nonce, 0);
        check("rst_midstate_zero", {31'd0, hasher_midstate == '0}, 1);
        check("rst_work_ready", {31'd0, work_ready}, 1);

        // 1: plain range, single hit
        gn_ready = 1'b1;
        hits.push_back(32'd150);
        exp_q.push_back(32'd150);
        send_work(32'd100, 32'd199);
        check("t1_first_nonce", hasher_nonce, 32'd100);
        check("t1_midstate", {31'd0, hasher_midstate == {8{32'd100 ^ 32'h1234_5678}}}, 1);
        check("t1_data", {31'd0, hasher_data == {3{32'd199 ^ 32'h0BAD_F00D}}}, 1);
        wait_idle(c, 400);
        check("t1_busy_cycles", c, L + 100);
        check("t1_nonce_hold", hasher_nonce, 32'd199);
        tick(4);
        check("t1_drained", exp_q.size(), 0);

        // 2: wrapping range
        do_reset();
        gn_ready = 1'b1;
        hits.push_back(32'hFFFF_FFFF);
        hits.push_back(32'h0);
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h0);
        send_work(32'hFFFF_FFFE, 32'd1);
        wait_idle(c, 100);
        check("t2_busy_cycles", c, L + 4);
        tick(4);
        check("t2_drained", exp_q.size(), 0);

        // 3: single-nonce range never enters RUN
        do_reset();
        gn_ready = 1'b1;
        hits.push_back(32'd5);
        exp_q.push_back(32'd5);
        saw_run = 1'b0;
        send_work(32'd5, 32'd5);
        wait_idle(c, 100);
        check("t3_busy_cycles", c, L + 1);
        check("t3_no_run", {31'd0, saw_run}, 0);
        tick(4);
        check("t3_drained", exp_q.size(), 0);

        // 4a: FIFO fills with no consumer, fifth hit dropped
        do_reset();
        for (int i = 10; i <= 14; i++) hits.push_back(32'(i));
        for (int i = 10; i <= 13; i++) exp_q.push_back(32'(i));
        send_work(32'd10, 32'd14);
        wait_idle(c, 100);
        check("t4_busy_cycles", c, L + 5);
        check("t4_overflow", {31'd0, gn_overflow}, 1);
        check("t4_gn_valid", {31'd0, gn_valid}, 1);
        gn_ready = 1'b1;
        tick(6);
        gn_ready = 1'b0;
        check("t4_drained", exp_q.size(), 0);
        check("t4_overflow_sticky", {31'd0, gn_overflow}, 1);
        check("t4_empty", {31'd0, gn_valid}, 0);

        // 4b: pop coincides with the push on full, nothing lost
        do_reset();
        check("t4b_overflow_cleared", {31'd0, gn_overflow}, 0);
        for (int i = 10; i <= 14; i++) hits.push_back(32'(i));
        for (int i = 10; i <= 14; i++) exp_q.push_back(32'(i));
        send_work(32'd10, 32'd14);
        tick(L + 4);
        gn_ready = 1'b1;
        wait_idle(c, 100);
        tick(8);
        check("t4b_drained", exp_q.size(), 0);
        check("t4b_no_overflow", {31'd0, gn_overflow}, 0);

        // 5: second work item arrives while the first is running
        do_reset();
        gn_ready = 1'b1;
        hits.push_back(32'd3);
        hits.push_back(32'd15);
        hits.push_back(32'd5002);
        exp_q.push_back(32'd3);
`ifdef SCHED_PENDING_WORK_EN
        exp_q.push_back(32'd15);
`endif
        exp_q.push_back(32'd5002);
        send_work(32'd0, 32'd999);
        tick(19);
        send_work(32'd5000, 32'd5009);
`ifdef SCHED_PENDING_WORK_EN
        check("t5_ready_pending", {31'd0, work_ready}, 0);
        wait_idle(c, 1200);
        check("t5_a_end", hasher_nonce, 32'd999);
        tick(1);
        check("t5_b_busy", {31'd0, busy}, 1);
        check("t5_b_start", hasher_nonce, 32'd5000);
        wait_idle(c, 100);
        check("t5_b_busy_cycles", c, L + 10);
`else
        check("t5_ready_busy", {31'd0, work_ready}, 1);
        check("t5_b_start", hasher_nonce, 32'd5000);
        wait_idle(c, 1200);
        check("t5_b_busy_cycles", c, L + 10);
        check("t5_b_end", hasher_nonce, 32'd5009);
`endif
        tick(4);
        check("t5_drained", exp_q.size(), 0);

        // 6: reset mid-run with queued golden nonces
        do_reset();
        hits.push_back(32'd1);
        hits.push_back(32'd2);
        send_work(32'd0, 32'd99);
        tick(29);
        check("t6_busy_before", {31'd0, busy}, 1);
        check("t6_gn_valid_before", {31'd0, gn_valid}, 1);
        reset = 1'b1;
        tick(1);
        check("t6_busy", {31'd0, busy}, 0);
        check("t6_gn_valid", {31'd0, gn_valid}, 0);
        check("t6_nonce", hasher_nonce, 0);
        check("t6_overflow", {31'd0, gn_overflow}, 0);
        reset = 1'b0;
        hits.delete();
        tick(3);
        check("t6_stays_idle", {30'd0, busy, gn_valid}, 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
